// File: rtl/cnn_pkg.sv
// Shared types and constants for the 3x3 binary-window convolution stage.
// relu_sat is the post-accumulate ReLU, arithmetic shift and 8-bit clamp.
package cnn_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    POST = 2'd2,
    OUT  = 2'd3
  } conv_state_t;

  localparam int TAPS      = 9;
  localparam int FMAP_W    = 26;
  localparam int BIAS_ADDR = 9;
  localparam int ACC_W     = 12;

  // Negative sums clamp to zero; positive sums are shifted, then clamped to 255.
  function automatic logic [7:0] relu_sat(input logic signed [ACC_W-1:0] s,
                                          input int unsigned sh);
    logic signed [ACC_W-1:0] r;
    r = s >>> sh;
    if (s < 0)
      return 8'd0;
    if (r > 12'sd255)
      return 8'hFF;
    return r[7:0];
  endfunction

endpackage

// File: rtl/cnn_conv_mac.sv
// Weight/bias register file, tap-indexed weight mux, 12-bit signed accumulator
// and the combinational bias/ReLU/shift/saturate path feeding the output register.
module cnn_conv_mac
  import cnn_pkg::*;
#(
  parameter int SHIFT = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_wt_wr,
  input  logic [3:0] i_wt_addr,
  input  logic [7:0] i_wt_data,
  input  logic       i_acc_clr,
  input  logic       i_acc_en,
  input  logic [3:0] i_tap,
  input  logic       i_din,
  output logic [7:0] o_feat
);

  logic signed [7:0]       r_wt [TAPS];
  logic signed [7:0]       r_bias;
  logic signed [ACC_W-1:0] r_acc;

  logic signed [7:0]       w_wt_sel;
  logic signed [ACC_W-1:0] w_wt_ext;
  logic signed [ACC_W-1:0] w_bias_ext;
  logic signed [ACC_W-1:0] w_sum;

  // Coefficients are deliberately not reset: they survive rst and frame_clr.
  always_ff @(posedge clk) begin
    if (i_wt_wr) begin
      if (i_wt_addr < 4'(TAPS))
        r_wt[i_wt_addr] <= i_wt_data;
      else if (i_wt_addr == 4'(BIAS_ADDR))
        r_bias <= i_wt_data;
    end
  end

  assign w_wt_sel   = (i_tap < 4'(TAPS)) ? r_wt[i_tap] : 8'sd0;
  assign w_wt_ext   = {{(ACC_W-8){w_wt_sel[7]}}, w_wt_sel};
  assign w_bias_ext = {{(ACC_W-8){r_bias[7]}}, r_bias};

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      r_acc <= '0;
    else if (i_acc_clr)
      r_acc <= '0;
    else if (i_acc_en && i_din)
      r_acc <= r_acc + w_wt_ext;
  end

  // Worst case |acc + bias| is 1280, so 12 bits never overflow.
  assign w_sum  = r_acc + w_bias_ext;
  assign o_feat = relu_sat(w_sum, SHIFT);

endmodule

// File: rtl/cnn_conv3x3.sv
// Convolution stage control: window FSM, tap counter, frame window counter and
// the result handshake around the cnn_conv_mac datapath.
module cnn_conv3x3
  import cnn_pkg::*;
#(
  parameter int SHIFT    = 2,
  parameter int FMAP_PIX = FMAP_W * FMAP_W
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        frame_clr,
  input  logic        strt,
  input  logic        din,
  output logic        bsy,
  input  logic        wt_wr,
  input  logic [3:0]  wt_addr,
  input  logic [7:0]  wt_data,
  output logic        res_vld,
  input  logic        res_rdy,
  output logic [7:0]  res_data,
  output logic        frame_done,
  output logic [9:0]  win_cnt,
  output conv_state_t dbg_state
);

  conv_state_t r_state;
  conv_state_t w_next;
  logic [3:0]  r_tap;
  logic        r_res_vld;
  logic [7:0]  r_res_data;
  logic        r_frame_done;
  logic [9:0]  r_win_cnt;

  logic        w_acc_clr;
  logic        w_acc_en;
  logic        w_accept;
  logic        w_wt_wr;
  logic [7:0]  w_feat;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      r_state <= IDLE;
    else
      r_state <= w_next;
  end

  always_comb begin
    w_next    = r_state;
    w_acc_clr = 1'b0;
    w_acc_en  = 1'b0;
    w_accept  = 1'b0;
    if (frame_clr) begin
      w_next = IDLE;
    end else begin
      case (r_state)
        IDLE: begin
          if (strt) begin
            w_next    = ACC;
            w_acc_clr = 1'b1;
          end
        end
        ACC: begin
          w_acc_en = 1'b1;
          if (r_tap == 4'(TAPS - 1))
            w_next = POST;
        end
        POST: w_next = OUT;
        OUT: begin
          if (res_rdy) begin
            w_accept = 1'b1;
            w_next   = IDLE;
          end
        end
        default: w_next = IDLE;
      endcase
    end
  end

  // The first ACC edge samples tap 0, absorbing one cycle of RAM read latency.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      r_tap <= '0;
    else if (w_acc_clr)
      r_tap <= '0;
    else if (w_acc_en)
      r_tap <= r_tap + 4'd1;
  end

  assign w_wt_wr = wt_wr && (r_state == IDLE);

  cnn_conv_mac #(
    .SHIFT(SHIFT)
  ) u_mac (
    .clk       (clk),
    .rst       (rst),
    .i_wt_wr   (w_wt_wr),
    .i_wt_addr (wt_addr),
    .i_wt_data (wt_data),
    .i_acc_clr (w_acc_clr),
    .i_acc_en  (w_acc_en),
    .i_tap     (r_tap),
    .i_din     (din),
    .o_feat    (w_feat)
  );

  // res_vld/res_rdy: a result transfers on an edge where both are high;
  // while res_rdy is low, res_vld and res_data hold their values unchanged.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_res_vld    <= 1'b0;
      r_res_data   <= '0;
      r_frame_done <= 1'b0;
      r_win_cnt    <= '0;
    end else begin
      r_frame_done <= 1'b0;
      if (frame_clr) begin
        r_res_vld <= 1'b0;
        r_win_cnt <= '0;
      end else if (r_state == POST) begin
        r_res_vld  <= 1'b1;
        r_res_data <= w_feat;
      end else if (w_accept) begin
        r_res_vld <= 1'b0;
        if (r_win_cnt == 10'(FMAP_PIX - 1)) begin
          r_win_cnt    <= '0;
          r_frame_done <= 1'b1;
        end else begin
          r_win_cnt <= r_win_cnt + 10'd1;
        end
      end
    end
  end

  assign bsy        = (r_state != IDLE);
  assign res_vld    = r_res_vld;
  assign res_data   = r_res_data;
  assign frame_done = r_frame_done;
  assign win_cnt    = r_win_cnt;
  assign dbg_state  = r_state;

endmodule

// File: tb/tb_cnn_conv3x3.sv
// Bench for cnn_conv3x3: two instances (SHIFT=0 and SHIFT=2) share one stimulus
// stream and are checked every cycle against a timeline model of the window.
module tb_cnn_conv3x3;
  import cnn_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, frame_clr, strt, din, wt_wr, res_rdy;
  logic [3:0]  wt_addr;
  logic [7:0]  wt_data;
  logic [1:0]  bsy, res_vld, frame_done;
  logic [7:0]  res_data [2];
  logic [9:0]  win_cnt [2];
  conv_state_t dbg_state [2];

  cnn_conv3x3 #(.SHIFT(0)) u_dut0 (
    .clk(clk), .rst(rst), .frame_clr(frame_clr), .strt(strt), .din(din),
    .bsy(bsy[0]), .wt_wr(wt_wr), .wt_addr(wt_addr), .wt_data(wt_data),
    .res_vld(res_vld[0]), .res_rdy(res_rdy), .res_data(res_data[0]),
    .frame_done(frame_done[0]), .win_cnt(win_cnt[0]), .dbg_state(dbg_state[0])
  );

  cnn_conv3x3 #(.SHIFT(2)) u_dut1 (
    .clk(clk), .rst(rst), .frame_clr(frame_clr), .strt(strt), .din(din),
    .bsy(bsy[1]), .wt_wr(wt_wr), .wt_addr(wt_addr), .wt_data(wt_data),
    .res_vld(res_vld[1]), .res_rdy(res_rdy), .res_data(res_data[1]),
    .frame_done(frame_done[1]), .win_cnt(win_cnt[1]), .dbg_state(dbg_state[1])
  );

  // ---------------- scoreboard / model state ----------------
  int         checks = 0;
  int         errors = 0;
  int         cyc = 0;
  int         m_w [9];
  int         m_bias = 0;
  bit         m_act = 1'b0;
  bit         m_out = 1'b0;
  int         m_c0 = 0;
  bit [8:0]   m_pat = '0;
  int         m_win = 0;
  bit         m_fd = 1'b0;
  int         last_res [2];
  int         fd_seen = 0;
  int         fd0 = 0;
  logic [15:0] exp_q [$];   // {SHIFT=2 result, SHIFT=0 result}

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s act=%0d exp=%0d cyc=%0d", name, act, exp, cyc);
    end
  endtask

  // Feature value straight from the arithmetic definition.
  function automatic int feat(input bit [8:0] pat, input int sh);
    int s;
    s = m_bias;
    for (int k = 0; k < 9; k++)
      if (pat[k]) s += m_w[k];
    if (s < 0) return 0;
    s = s >>> sh;
    return (s > 255) ? 255 : s;
  endfunction

  // Called once per cycle at the negedge: checks outputs, then applies the
  // inputs that the coming posedge will see.
  task automatic model_cycle();
    bit idle;
    if (rst) begin
      m_act = 1'b0; m_out = 1'b0; m_win = 0; m_fd = 1'b0;
      exp_q.delete();
      for (int i = 0; i < 2; i++) begin
        chk("rst_bsy",  int'(bsy[i]), 0);
        chk("rst_vld",  int'(res_vld[i]), 0);
        chk("rst_data", int'(res_data[i]), 0);
        chk("rst_fd",   int'(frame_done[i]), 0);
        chk("rst_win",  int'(win_cnt[i]), 0);
      end
      return;
    end
    // Result becomes visible ten edges after the edge that took strt.
    if (m_act && cyc == m_c0 + 10) begin
      exp_q.push_back({8'(feat(m_pat, 2)), 8'(feat(m_pat, 0))});
      m_act = 1'b0;
      m_out = 1'b1;
    end
    for (int i = 0; i < 2; i++) begin
      chk("win_cnt",    int'(win_cnt[i]), m_win);
      chk("frame_done", int'(frame_done[i]), int'(m_fd));
      chk("bsy",        int'(bsy[i]), int'(m_act || m_out));
      chk("res_vld",    int'(res_vld[i]), int'(m_out));
    end
    if (m_out) begin
      chk("res_data_s0", int'(res_data[0]), int'(exp_q[0][7:0]));
      chk("res_data_s2", int'(res_data[1]), int'(exp_q[0][15:8]));
    end
    fd_seen += int'(frame_done[0]);
    if (m_act && cyc >= m_c0 && cyc <= m_c0 + 8)
      m_pat[cyc - m_c0] = din;
    idle = !m_act && !m_out;
    m_fd = 1'b0;
    if (idle && wt_wr) begin
      if (wt_addr < 4'd9) m_w[wt_addr] = int'($signed(wt_data));
      else if (wt_addr == 4'd9) m_bias = int'($signed(wt_data));
    end
    if (frame_clr) begin
      m_act = 1'b0; m_out = 1'b0; m_win = 0;
      exp_q.delete();
    end else if (m_out && res_rdy) begin
      last_res[0] = int'(res_data[0]);
      last_res[1] = int'(res_data[1]);
      void'(exp_q.pop_front());
      m_out = 1'b0;
      if (m_win == 675) begin m_win = 0; m_fd = 1'b1; end
      else m_win++;
    end else if (idle && strt) begin
      m_act = 1'b1;
      m_c0  = cyc + 1;
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic step();
    @(negedge clk);
    model_cycle();
    @(posedge clk);
    cyc++;
    #1;
  endtask

  task automatic write_wt(input logic [3:0] a, input logic [7:0] d);
    wt_wr = 1'b1; wt_addr = a; wt_data = d;
    step();
    wt_wr = 1'b0;
  endtask

  task automatic load_all(input logic [7:0] w, input logic [7:0] b);
    for (int k = 0; k < 9; k++) write_wt(4'(k), w);
    write_wt(4'd9, b);
  endtask

  // One window: taps driven on the 9 cycles after the strt edge, then the
  // result is held for 'hold' cycles before res_rdy; 'poke' fires a strt and
  // a weight write while the result is waiting.
  task automatic run_window(input bit [8:0] pat, input int hold, input bit poke);
    strt = 1'b1;
    res_rdy = (hold == 0);
    step();
    strt = 1'b0;
    for (int k = 0; k < 9; k++) begin
      din = pat[k];
      step();
    end
    din = 1'($urandom_range(0, 1));
    step();
    for (int h = 0; h < hold; h++) begin
      if (poke && h == 0) begin
        strt = 1'b1; wt_wr = 1'b1; wt_addr = 4'd0; wt_data = 8'd99;
      end
      step();
      strt = 1'b0; wt_wr = 1'b0;
    end
    res_rdy = 1'b1;
    step();
    res_rdy = 1'($urandom_range(0, 1));
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst = 1'b0; frame_clr = 1'b0; strt = 1'b0; din = 1'b0;
    wt_wr = 1'b0; wt_addr = '0; wt_data = '0; res_rdy = 1'b0;
    for (int k = 0; k < 9; k++) m_w[k] = 0;
    last_res[0] = -1; last_res[1] = -1;
    #2 rst = 1'b1;
    step(); step();
    for (int i = 0; i < 2; i++) chk("rst_state", int'(dbg_state[i]), int'(IDLE));
    rst = 1'b0;
    step();

    load_all(8'd1, 8'd0);
    run_window(9'h1FF, 0, 0);
    chk("ones_s0", last_res[0], 9);
    chk("ones_s2", last_res[1], 2);
    run_window(9'h000, 0, 0);
    chk("zeros_s0", last_res[0], 0);

    load_all(8'h80, 8'd0);
    run_window(9'h1FF, 0, 0);
    chk("relu_s0", last_res[0], 0);
    chk("relu_s2", last_res[1], 0);
    write_wt(4'd4, 8'd5);
    run_window(9'h010, 0, 0);
    chk("tap4_s0", last_res[0], 5);
    chk("tap4_s2", last_res[1], 1);

    load_all(8'd127, 8'd127);
    run_window(9'h1FF, 0, 0);
    chk("sat_s0", last_res[0], 255);
    chk("sat_s2", last_res[1], 255);

    for (int k = 0; k < 9; k++) write_wt(4'(k), 8'(k + 1));
    write_wt(4'd9, 8'hFD);
    run_window(9'h1FF, 5, 1'b1);
    chk("hold_s0", last_res[0], 42);
    chk("hold_s2", last_res[1], 10);
    run_window(9'h1FF, 0, 0);
    chk("wt_kept_s0", last_res[0], 42);

    for (int a = 0; a < 16; a++) write_wt(4'(a), 8'($urandom));
    repeat (30) run_window(9'($urandom), $urandom_range(0, 3), 1'($urandom_range(0, 1)));

    frame_clr = 1'b1;
    step();
    frame_clr = 1'b0;
    chk("clr_win", int'(win_cnt[0]), 0);
    fd0 = fd_seen;
    repeat (676) run_window(9'($urandom), 0, 0);
    chk("frame_fd_hi", int'(frame_done[0]), 1);
    chk("frame_win0", int'(win_cnt[0]), 0);
    step();
    chk("frame_fd_once", fd_seen - fd0, 1);
    chk("frame_fd_lo", int'(frame_done[0]), 0);

    run_window(9'($urandom), 0, 0);
    run_window(9'($urandom), 1, 0);
    strt = 1'b1;
    step();
    strt = 1'b0;
    for (int k = 0; k < 4; k++) begin
      din = 1'($urandom_range(0, 1));
      step();
    end
    frame_clr = 1'b1;
    step();
    frame_clr = 1'b0;
    for (int i = 0; i < 2; i++) begin
      chk("clr_bsy", int'(bsy[i]), 0);
      chk("clr_win3", int'(win_cnt[i]), 0);
      chk("clr_state", int'(dbg_state[i]), int'(IDLE));
    end
    repeat (15) step();

    strt = 1'b1; frame_clr = 1'b1;
    step();
    strt = 1'b0; frame_clr = 1'b0;
    chk("clr_vs_strt", int'(bsy[0]), 0);
    repeat (3) step();

    load_all(8'd1, 8'd0);
    run_window(9'h1FF, 0, 0);
    chk("pre_rst_s0", last_res[0], 9);
    strt = 1'b1;
    step();
    strt = 1'b0; din = 1'b1;
    step(); step();
    rst = 1'b1;
    #1;
    for (int i = 0; i < 2; i++) begin
      chk("arst_bsy",   int'(bsy[i]), 0);
      chk("arst_vld",   int'(res_vld[i]), 0);
      chk("arst_data",  int'(res_data[i]), 0);
      chk("arst_win",   int'(win_cnt[i]), 0);
      chk("arst_state", int'(dbg_state[i]), int'(IDLE));
    end
    step();
    rst = 1'b0;
    step();
    load_all(8'd2, 8'd1);
    run_window(9'h0F0, 0, 0);
    chk("post_rst_s0", last_res[0], 9);
    chk("post_rst_s2", last_res[1], 2);
    repeat (3) step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL timeout cyc=%0d", cyc);
    $fatal(1);
  end

endmodule
